// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives ID/EX fields, consumes stall/flush controls).
// slave : controller side.
interface hazard_stall_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_md_use;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_md_start;
  logic       ex_md_is_div;
  logic       branch_taken;
  logic       stall_pc;
  logic       stall_ifid;
  logic       flush_ifid;
  logic       flush_idex;
  logic       md_busy;
  logic       md_done;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_use,
           ex_rd, ex_mem_read, ex_md_start, ex_md_is_div, branch_taken,
    input  stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy, md_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_use,
           ex_rd, ex_mem_read, ex_md_start, ex_md_is_div, branch_taken,
    output stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy, md_done
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Detects load-use hazards, tracks the multi-cycle MUL/DIV unit with a
// busy-counter FSM and applies taken-branch flushes. Stall/flush outputs are
// combinational; only the MUL/DIV sequencing is registered.
// Optional feature: define HAZ_PERF_CNT_EN to add the stall_cycles counter port.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,   // >= 2
  parameter int DIV_LAT = 32   // >= 2, <= 63
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_stall_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter starts at LAT-1: the issue cycle itself is the first of LAT cycles.
  localparam logic [5:0] MUL_INIT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 1);

  state_t     state, next_state;
  logic [5:0] md_cnt, next_cnt;
  logic       md_busy, md_done;
  logic       load_use, md_hold;
  logic       stall_pc, stall_ifid, flush_ifid, flush_idex;

  // MUL/DIV state register and busy counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= next_state;
      md_cnt <= next_cnt;
    end
  end

  // Next-state / counter logic; a start while BUSY cannot happen legally
  // (ID was held) and is ignored.
  // NOTE: defaults assigned first so no path leaves a variable unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = md_cnt;
    unique case (state)
      IDLE: begin
        if (hz.ex_md_start) begin
          next_state = BUSY;
          next_cnt   = hz.ex_md_is_div ? DIV_INIT : MUL_INIT;
        end
      end
      BUSY: begin
        if (md_cnt == 6'd1) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt   = md_cnt - 6'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // MUL/DIV status decoded from the registered state.
  always_comb begin
    md_busy = (state == BUSY);
    md_done = (state == BUSY) && (md_cnt == 6'd1);
  end

  // Hazard detection and prioritised stall/flush decision.
  always_comb begin
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
    // The done cycle releases the hold so the dependent instr advances then.
    md_hold  = hz.id_md_use && md_busy && !md_done;

    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (hz.branch_taken) begin
      // Branch flush wins; an in-flight MUL/DIV is already past EX and keeps going.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (load_use || md_hold) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  assign hz.stall_pc   = stall_pc;
  assign hz.stall_ifid = stall_ifid;
  assign hz.flush_ifid = flush_ifid;
  assign hz.flush_idex = flush_idex;
  assign hz.md_busy    = md_busy;
  assign hz.md_done    = md_done;

`ifdef HAZ_PERF_CNT_EN
  // Free-running count of PC stall cycles; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cycles <= '0;
    else if (stall_pc) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
